serial_word_deframer: RTL and testbench

- Consumes the 1-bit registered stream produced by the D flip-flop stage (its q output), one bit per qualified clock.
- Hunts for a sync pattern, then assembles the following WORD_W bits, MSB first, into a parallel word.
- Hands the word downstream over a valid/ready handshake through a single holding register.
- Sits directly downstream of the flip-flop stage in the serial capture path.

---
 rtl/serial_word_deframer.sv | 178 +++++++++++++++++
 tb/tb_serial_word_deframer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_deframer.sv
// serial_word_deframer
//   Hunts a serial bit stream for SYNC_PATTERN. After a match, the next WORD_W
//   bits are assembled MSB first into a word. The word goes downstream through
//   a single holding register with a valid/ready handshake.
//
//   Optional feature macro: DEFRAMER_PARITY_CHECK_EN
//     Adds a PARITY state that consumes one even-parity bit after the data.
//     A bad-parity word is discarded and parity_err pulses for one cycle.
//
// Ports:
//   clk         - clock; all state changes on its rising edge
//   rst_n       - asynchronous active-low reset
//   bit_in      - serial data bit
//   bit_valid   - bit_in is consumed only while this is high
//   word_out    - assembled word; held stable while word_valid=1
//   word_valid  - holding register is occupied
//   word_ready  - downstream takes word_out when word_valid && word_ready
//   sync_locked - high while collecting data (and parity) bits
//   overflow    - one-cycle pulse when a completed word is dropped
//   parity_err  - (parity build only) one-cycle pulse on a parity mismatch
module serial_word_deframer #(
  parameter int unsigned       WORD_W       = 8,
  parameter int unsigned       SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              sync_locked,
  output logic              overflow
`ifdef DEFRAMER_PARITY_CHECK_EN
  ,
  output logic              parity_err
`endif
);

  localparam int unsigned HCW = $clog2(SYNC_W + 1);
  localparam int unsigned BCW = $clog2(WORD_W);

  typedef enum logic [1:0] {S_HUNT, S_DATA, S_PARITY} state_e;

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sr_q, sr_d;
  logic [HCW-1:0]    hunt_q, hunt_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
`ifdef DEFRAMER_PARITY_CHECK_EN
  logic              perr_q, perr_d;
`endif

  logic [SYNC_W-1:0] sr_shift;
  logic [HCW:0]      hunt_inc;
  logic              complete;
  logic              load;
  logic [WORD_W-1:0] cand;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HUNT;
      sr_q    <= '0;
      hunt_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DEFRAMER_PARITY_CHECK_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      hunt_q  <= hunt_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
`ifdef DEFRAMER_PARITY_CHECK_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    hunt_d   = hunt_q;
    bcnt_d   = bcnt_q;
    data_d   = data_q;
    word_d   = word_q;
    ovf_d    = 1'b0;
`ifdef DEFRAMER_PARITY_CHECK_EN
    perr_d   = 1'b0;
`endif
    complete = 1'b0;
    cand     = data_q;
    sr_shift = {sr_q[SYNC_W-2:0], bit_in};
    hunt_inc = {1'b0, hunt_q} + (HCW+1)'(1);

    if (bit_valid) begin
      case (state_q)
        S_HUNT: begin
          sr_d   = sr_shift;
          hunt_d = (hunt_q == HCW'(SYNC_W)) ? hunt_q : hunt_q + HCW'(1);
          // Require a full window of received bits, so zeroed reset history
          // cannot form a false match.
          if ((sr_shift == SYNC_PATTERN) && (hunt_inc >= (HCW+1)'(SYNC_W))) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
        S_DATA: begin
          data_d = {data_q[WORD_W-2:0], bit_in};
          bcnt_d = bcnt_q + BCW'(1);
          if (bcnt_q == BCW'(WORD_W - 1)) begin
            bcnt_d = '0;
`ifdef DEFRAMER_PARITY_CHECK_EN
            state_d = S_PARITY;
`else
            state_d  = S_HUNT;
            sr_d     = '0;
            hunt_d   = '0;
            complete = 1'b1;
            cand     = {data_q[WORD_W-2:0], bit_in};
`endif
          end
        end
`ifdef DEFRAMER_PARITY_CHECK_EN
        S_PARITY: begin
          state_d = S_HUNT;
          sr_d    = '0;
          hunt_d  = '0;
          bcnt_d  = '0;
          // Even parity: data bits plus parity bit must XOR to zero.
          if (^{data_q, bit_in}) begin
            perr_d = 1'b1;
          end else begin
            complete = 1'b1;
            cand     = data_q;
          end
        end
`endif
        default: state_d = S_HUNT;
      endcase
    end

    // A load can coincide with a drain, which keeps word_valid high with no bubble.
    load = complete && (!valid_q || word_ready);
    if (complete && !load) ovf_d = 1'b1;
    if (load) word_d = cand;

    if (load)                       valid_d = 1'b1;
    else if (valid_q && word_ready) valid_d = 1'b0;
    else                            valid_d = valid_q;
  end

  // Output logic
  always_comb begin
    word_out    = word_q;
    word_valid  = valid_q;
    overflow    = ovf_q;
    sync_locked = (state_q != S_HUNT);
`ifdef DEFRAMER_PARITY_CHECK_EN
    parity_err  = perr_q;
`endif
  end

endmodule

// File: tb/tb_serial_word_deframer.sv
module tb_serial_word_deframer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       word_ready;
  logic [7:0] word_out;
  logic       word_valid;
  logic       sync_locked;
  logic       overflow;
  logic [7:0] z_word_out;
  logic       z_word_valid;
  logic       z_sync_locked;
  logic       z_overflow;
`ifdef DEFRAMER_PARITY_CHECK_EN
  logic       parity_err;
  logic       z_parity_err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_word_deframer #(.WORD_W(8), .SYNC_W(8), .SYNC_PATTERN(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .sync_locked(sync_locked), .overflow(overflow)
`ifdef DEFRAMER_PARITY_CHECK_EN
    , .parity_err(parity_err)
`endif
  );

  // All-zero sync pattern: exposes matches formed from reset-cleared history.
  serial_word_deframer #(.WORD_W(8), .SYNC_W(8), .SYNC_PATTERN(8'h00)) dut_z (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .word_out(z_word_out), .word_valid(z_word_valid), .word_ready(word_ready),
    .sync_locked(z_sync_locked), .overflow(z_overflow)
`ifdef DEFRAMER_PARITY_CHECK_EN
    , .parity_err(z_parity_err)
`endif
  );

  task automatic step(input logic b, input logic v);
    bit_in    = b;
    bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Sends sync + data (+ parity); word_ready takes rdy_last just before the final bit.
  task automatic send_frame(input logic [7:0] d, input logic par_flip,
                            input logic rdy_last, input int gap);
    logic [16:0] f;
    int n;
`ifdef DEFRAMER_PARITY_CHECK_EN
    f = {8'hA5, d, (^d) ^ par_flip};
    n = 17;
`else
    f = {1'b0, 8'hA5, d};
    n = 16;
    if (par_flip) f[16] = 1'b0;
`endif
    for (int i = n - 1; i >= 0; i--) begin
      if (i == 0) word_ready = rdy_last;
      step(f[i], 1'b1);
      if (i != 0) repeat (gap) step(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (word_out !== 8'h00) begin bad++; $display("FAIL rst_word_out got=%h exp=00", word_out); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_word_valid got=%b exp=0", word_valid); end
    total++; if (sync_locked !== 1'b0) begin bad++; $display("FAIL rst_sync_locked got=%b exp=0", sync_locked); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    total++; if (word_valid !== 1'b0 || sync_locked !== 1'b0) begin
      bad++; $display("FAIL idle_outputs got=%b%b exp=00", word_valid, sync_locked); end
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    total++; if (word_valid !== 1'b1 || word_out !== 8'h3C) begin
      bad++; $display("FAIL pre_async_word got=%b/%h exp=1/3c", word_valid, word_out); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (word_valid !== 1'b0 || word_out !== 8'h00) begin
      bad++; $display("FAIL async_rst_clear got=%b/%h exp=0/00", word_valid, word_out); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_basic_frame;
    logic [7:0] s;
    logic [7:0] d;
    s = 8'hA5;
    d = 8'h3C;
    word_ready = 1'b1;
    for (int i = 7; i >= 0; i--) step(s[i], 1'b1);
    total++; if (sync_locked !== 1'b1) begin bad++; $display("FAIL lock_after_sync got=%b exp=1", sync_locked); end
    for (int i = 7; i >= 1; i--) begin
      step(d[i], 1'b1);
      total++; if (sync_locked !== 1'b1 || word_valid !== 1'b0) begin
        bad++; $display("FAIL lock_during_data bit=%0d got=%b%b exp=10", i, sync_locked, word_valid); end
    end
    step(d[0], 1'b1);
`ifdef DEFRAMER_PARITY_CHECK_EN
    step(^d, 1'b1);
`endif
    total++; if (sync_locked !== 1'b0) begin bad++; $display("FAIL unlock_after_word got=%b exp=0", sync_locked); end
    total++; if (word_valid !== 1'b1 || word_out !== 8'h3C) begin
      bad++; $display("FAIL basic_word got=%b/%h exp=1/3c", word_valid, word_out); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%b exp=0", overflow); end
    step(1'b0, 1'b0);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_gapped;
    word_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 2);
    total++; if (word_valid !== 1'b1 || word_out !== 8'h3C) begin
      bad++; $display("FAIL gapped_word got=%b/%h exp=1/3c", word_valid, word_out); end
    step(1'b0, 1'b0);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL gapped_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_zeros;
    logic [7:0] s;
    logic [7:0] d;
    s = 8'hA5;
    d = 8'h81;
    word_ready = 1'b1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1);
      total++; if (sync_locked !== 1'b0) begin bad++; $display("FAIL zeros_no_lock bit=%0d got=%b exp=0", i, sync_locked); end
      if (i <= 15) begin
        total++; if (z_sync_locked !== (i >= 8)) begin
          bad++; $display("FAIL zero_pattern_lock bit=%0d got=%b exp=%b", i, z_sync_locked, (i >= 8)); end
      end
    end
    for (int i = 7; i >= 0; i--) begin
      step(s[i], 1'b1);
      total++; if (sync_locked !== (i == 0)) begin
        bad++; $display("FAIL sync_bit_lock bit=%0d got=%b exp=%b", i, sync_locked, (i == 0)); end
    end
    for (int i = 7; i >= 0; i--) step(d[i], 1'b1);
`ifdef DEFRAMER_PARITY_CHECK_EN
    step(^d, 1'b1);
`endif
    total++; if (word_valid !== 1'b1 || word_out !== 8'h81) begin
      bad++; $display("FAIL zeros_word got=%b/%h exp=1/81", word_valid, word_out); end
    step(1'b0, 1'b0);
  endtask

  task automatic test_overflow;
    word_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    total++; if (word_valid !== 1'b1 || word_out !== 8'h3C || overflow !== 1'b0) begin
      bad++; $display("FAIL ovf_first got=%b/%h/%b exp=1/3c/0", word_valid, word_out, overflow); end
    send_frame(8'h11, 1'b0, 1'b0, 0);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
    total++; if (word_out !== 8'h3C || word_valid !== 1'b1) begin
      bad++; $display("FAIL ovf_hold got=%b/%h exp=1/3c", word_valid, word_out); end
    step(1'b0, 1'b0);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
    word_ready = 1'b1;
    step(1'b0, 1'b0);
    total++; if (word_valid !== 1'b0 || word_out !== 8'h3C) begin
      bad++; $display("FAIL ovf_deliver got=%b/%h exp=0/3c", word_valid, word_out); end
  endtask

  task automatic test_back_to_back;
    word_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    total++; if (word_valid !== 1'b1 || word_out !== 8'h5A || overflow !== 1'b0) begin
      bad++; $display("FAIL b2b_load got=%b/%h/%b exp=1/5a/0", word_valid, word_out, overflow); end
    step(1'b0, 1'b0);
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", word_valid); end
  endtask

  task automatic test_reset_midframe;
    logic [11:0] f;
    f = {8'hA5, 4'h3};
    word_ready = 1'b1;
    for (int i = 11; i >= 0; i--) step(f[i], 1'b1);
    total++; if (sync_locked !== 1'b1) begin bad++; $display("FAIL midframe_locked got=%b exp=1", sync_locked); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (sync_locked !== 1'b0) begin bad++; $display("FAIL midframe_rst_unlock got=%b exp=0", sync_locked); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b1, 0);
    total++; if (word_valid !== 1'b1 || word_out !== 8'h5A) begin
      bad++; $display("FAIL midframe_next_word got=%b/%h exp=1/5a", word_valid, word_out); end
    step(1'b0, 1'b0);
  endtask

`ifdef DEFRAMER_PARITY_CHECK_EN
  task automatic test_parity;
    word_ready = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 0);
    total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL parity_err_pulse got=%b exp=1", parity_err); end
    total++; if (word_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL parity_drop got=%b/%b exp=0/0", word_valid, overflow); end
    step(1'b0, 1'b0);
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_err_one_cycle got=%b exp=0", parity_err); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic_frame;
    test_gapped;
    test_zeros;
    test_overflow;
    test_back_to_back;
    test_reset_midframe;
`ifdef DEFRAMER_PARITY_CHECK_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
